pipe_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the five-stage RISC-V pipeline. It watches the ID and EX stage fields and the data-memory handshake, and drives the stall, flush and `cancel` signals that hold the PC and pipeline registers or squash them. `cancel` feeds the control decoder, which then zeroes every enable for the instruction entering EX. It owns the pipeline's only multi-cycle sequencing: branch/jump flush windows and data-memory wait.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/hz_perf_cnt.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V opcode constants and hazard sequencer state encoding.
package rv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;

  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_perf_cnt.sv
// Free-running wrap-around event counter; only built when PIPE_HAZARD_PERF_EN is defined.
`ifdef PIPE_HAZARD_PERF_EN
module hz_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, jump flush windows, memory wait.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_op,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_lw_en,
  input  logic             jmp_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             cancel,
  output logic             exmem_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t         st_q, st_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic uses_rs1_c, uses_rs2_c, load_use_c, mem_wait_c;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, cancel_c, exmem_stall_c;

  assign uses_rs1_c = (id_op != OP_JAL);
  assign uses_rs2_c = (id_op == OP_R) || (id_op == OP_BR) || (id_op == OP_ST);
  assign load_use_c = ex_lw_en && (ex_rd != 5'd0) &&
                      ((uses_rs1_c && (ex_rd == id_rs1)) || (uses_rs2_c && (ex_rd == id_rs2)));
  assign mem_wait_c = mem_req && !mem_ready;

  // Next state and Mealy outputs; MEM_WAIT shares RUN evaluation so the exit cycle acts as RUN.
  always_comb begin
    st_d          = st_q;
    fcnt_d        = fcnt_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    cancel_c      = 1'b0;
    exmem_stall_c = 1'b0;
    case (st_q)
      ST_FLUSH: begin
        if (mem_wait_c) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
        end else begin
          ifid_flush_c = 1'b1;
          cancel_c     = 1'b1;
          fcnt_d       = fcnt_q - FCNT_W'(1);
          if (fcnt_q == FCNT_W'(1)) st_d = ST_RUN;
        end
      end
      default: begin
        st_d = ST_RUN;
        if (mem_wait_c) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
          st_d          = ST_MEM_WAIT;
        end else if (jmp_en) begin
          ifid_flush_c = 1'b1;
          cancel_c     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            st_d   = ST_FLUSH;
            fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (load_use_c) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          cancel_c     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_RUN;
      fcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Reset forces every control output low without waiting for a clock.
  assign pc_stall    = rst_n & pc_stall_c;
  assign ifid_stall  = rst_n & ifid_stall_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign cancel      = rst_n & cancel_c;
  assign exmem_stall = rst_n & exmem_stall_c;

`ifdef PIPE_HAZARD_PERF_EN
  hz_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_stall),
    .cnt   (stall_cnt)
  );

  hz_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=2 and FLUSH_CYCLES=1 instances.
module tb_pipe_hazard_ctrl;
  import rv_pkg::*;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_lw_en, jmp_en, mem_req, mem_ready;

  logic        pc_stall_a, ifid_stall_a, ifid_flush_a, cancel_a, exmem_stall_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic        pc_stall_b, ifid_stall_b, ifid_flush_b, cancel_b, exmem_stall_b;
  logic [31:0] stall_cnt_b, flush_cnt_b;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_lw_en(ex_lw_en), .jmp_en(jmp_en), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_stall_a), .ifid_stall(ifid_stall_a),
    .ifid_flush(ifid_flush_a), .cancel(cancel_a), .exmem_stall(exmem_stall_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_lw_en(ex_lw_en), .jmp_en(jmp_en), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_stall_b), .ifid_stall(ifid_stall_b),
    .ifid_flush(ifid_flush_b), .cancel(cancel_b), .exmem_stall(exmem_stall_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a count of owed squash cycles; memory wait freezes it, otherwise it drains before new events.
  function automatic void model_step(input int owed, input int fc,
                                     output logic [4:0] o, output int owed_n);
    logic u1, u2, lu, mw;
    u1 = (id_op != OP_JAL);
    u2 = (id_op == OP_R) || (id_op == OP_BR) || (id_op == OP_ST);
    lu = ex_lw_en && (ex_rd != 5'd0) && ((u1 && ex_rd == id_rs1) || (u2 && ex_rd == id_rs2));
    mw = mem_req && !mem_ready;
    o = 5'b0;
    owed_n = owed;
    if (!rst_n) owed_n = 0;
    else if (mw) o = 5'b11001;
    else if (owed > 0) begin o = 5'b00110; owed_n = owed - 1; end
    else if (jmp_en) begin o = 5'b00110; owed_n = fc - 1; end
    else if (lu) o = 5'b11010;
  endfunction

  int          owed_a = 0, owed_b = 0;
  logic [31:0] m_scnt_a = 0, m_fcnt_a = 0, m_scnt_b = 0, m_fcnt_b = 0;

  always @(posedge clk or negedge rst_n) begin : model_upd
    logic [4:0] oa, ob;
    int na, nb;
    if (!rst_n) begin
      owed_a = 0; owed_b = 0;
      m_scnt_a = 0; m_fcnt_a = 0; m_scnt_b = 0; m_fcnt_b = 0;
    end else begin
      model_step(owed_a, 2, oa, na);
      model_step(owed_b, 1, ob, nb);
      if (oa[4]) m_scnt_a = m_scnt_a + 1;
      if (oa[2]) m_fcnt_a = m_fcnt_a + 1;
      if (ob[4]) m_scnt_b = m_scnt_b + 1;
      if (ob[2]) m_fcnt_b = m_fcnt_b + 1;
      owed_a = na;
      owed_b = nb;
    end
  end

  function automatic logic [31:0] pc(input logic [31:0] x);
    return PERF ? x : 32'd0;
  endfunction

  always @(negedge clk) begin : compare
    logic [4:0] ea, eb;
    int dn;
    model_step(owed_a, 2, ea, dn);
    model_step(owed_b, 1, eb, dn);
    chk("outs_fc2", 32'({pc_stall_a, ifid_stall_a, ifid_flush_a, cancel_a, exmem_stall_a}), 32'(ea));
    chk("outs_fc1", 32'({pc_stall_b, ifid_stall_b, ifid_flush_b, cancel_b, exmem_stall_b}), 32'(eb));
    chk("stall_cnt_fc2", stall_cnt_a, pc(m_scnt_a));
    chk("flush_cnt_fc2", flush_cnt_a, pc(m_fcnt_a));
    chk("stall_cnt_fc1", stall_cnt_b, pc(m_scnt_b));
    chk("flush_cnt_fc1", flush_cnt_b, pc(m_fcnt_b));
  end

  task automatic idle();
    id_op = OP_I; id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd0;
    ex_lw_en = 1'b0; jmp_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({pc_stall_a, ifid_stall_a, ifid_flush_a, cancel_a, exmem_stall_a});
  endfunction

  logic [6:0] t_op  [8] = '{OP_I, OP_I, OP_ST, OP_BR, OP_JAL, OP_LD, OP_JALR, OP_R};
  logic [4:0] t_rs1 [8] = '{5'd3, 5'd1, 5'd1, 5'd7, 5'd4, 5'd0, 5'd6, 5'd2};
  logic [4:0] t_rs2 [8] = '{5'd9, 5'd3, 5'd7, 5'd1, 5'd0, 5'd0, 5'd6, 5'd2};
  logic [4:0] t_rd  [8] = '{5'd3, 5'd3, 5'd7, 5'd7, 5'd4, 5'd0, 5'd6, 5'd2};
  logic       t_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    idle();
    #3 chk("reset_outs", outs_a(), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Load-use on rs2 of an R-type: one bubble, then clear
    cyc(); ex_lw_en = 1'b1; ex_rd = 5'd5; id_op = OP_R; id_rs1 = 5'd1; id_rs2 = 5'd5;
    at_neg();
    chk("lu_pc_stall", 32'(pc_stall_a), 32'd1);
    chk("lu_ifid_stall", 32'(ifid_stall_a), 32'd1);
    chk("lu_cancel", 32'(cancel_a), 32'd1);
    chk("lu_no_flush", 32'(ifid_flush_a), 32'd0);
    cyc(); ex_lw_en = 1'b0;
    at_neg(); chk("lu_clear", outs_a(), 32'd0);

    // Operand-usage table: x0 and JAL/I-type rs2 never stall
    for (int i = 0; i < 8; i++) begin
      cyc(); ex_lw_en = 1'b1; id_op = t_op[i]; id_rs1 = t_rs1[i]; id_rs2 = t_rs2[i]; ex_rd = t_rd[i];
      at_neg(); chk("lu_table", 32'(pc_stall_a), 32'(t_exp[i]));
    end
    cyc(); idle();

    // Jump pulse: two-cycle window for FC=2, single cycle for FC=1
    cyc(); jmp_en = 1'b1;
    at_neg();
    chk("jmp_flush_fc2", 32'(ifid_flush_a), 32'd1);
    chk("jmp_flush_fc1", 32'(ifid_flush_b), 32'd1);
    chk("jmp_cancel_fc1", 32'(cancel_b), 32'd1);
    cyc(); jmp_en = 1'b0;
    at_neg();
    chk("flush2_fc2", 32'(ifid_flush_a), 32'd1);
    chk("flush2_fc1", 32'(ifid_flush_b), 32'd0);
    cyc(); at_neg(); chk("flush_done", outs_a(), 32'd0);

    // Held jump with simultaneous load-use: flush must win over ifid_stall
    cyc(); jmp_en = 1'b1; ex_lw_en = 1'b1; ex_rd = 5'd5; id_op = OP_R; id_rs2 = 5'd5;
    at_neg(); chk("flush_over_lu", 32'(ifid_stall_a), 32'd0);
    repeat (3) cyc();
    cyc(); idle();
    repeat (2) cyc();

    // Memory wait 3 cycles with jump pending, then flush in the ready cycle
    mem_req = 1'b1; mem_ready = 1'b0; jmp_en = 1'b1;
    at_neg();
    chk("mw_pc_stall", 32'(pc_stall_a), 32'd1);
    chk("mw_exmem_stall", 32'(exmem_stall_a), 32'd1);
    chk("mw_cancel", 32'(cancel_a), 32'd0);
    cyc(); cyc();
    at_neg(); chk("mw3", outs_a(), 32'b11001);
    cyc(); mem_ready = 1'b1;
    at_neg(); chk("mw_ready_flush", outs_a(), 32'b00110);
    cyc(); mem_req = 1'b0; mem_ready = 1'b0; jmp_en = 1'b0;
    at_neg();
    chk("mw_post_fc2", 32'(ifid_flush_a), 32'd1);
    chk("mw_post_fc1", 32'(ifid_flush_b), 32'd0);
    cyc(); idle();

    // Memory wait inside FLUSH freezes the window
    cyc(); jmp_en = 1'b1;
    cyc(); jmp_en = 1'b0; mem_req = 1'b1;
    at_neg(); chk("flush_mw", outs_a(), 32'b11001);
    cyc(); cyc(); mem_req = 1'b0;
    at_neg(); chk("flush_resume", 32'(ifid_flush_a), 32'd1);
    cyc(); at_neg(); chk("flush_resume_done", outs_a(), 32'd0);

    // Asynchronous reset in the middle of FLUSH
    cyc(); jmp_en = 1'b1;
    cyc(); jmp_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs_a(), 32'd0);
    chk("rst_async_cnt", stall_cnt_a | flush_cnt_a, 32'd0);
    #1 rst_n = 1'b1;
    at_neg(); chk("after_rst", outs_a(), 32'd0);
    cyc(); at_neg(); chk("after_rst2", outs_a(), 32'd0);

    // Counters: one load-use plus one jump
    cyc(); ex_lw_en = 1'b1; ex_rd = 5'd5; id_op = OP_R; id_rs2 = 5'd5;
    cyc(); idle(); jmp_en = 1'b1;
    cyc(); jmp_en = 1'b0;
    cyc(); cyc();
    at_neg();
    chk("perf_stall_fc2", stall_cnt_a, PERF ? 32'd1 : 32'd0);
    chk("perf_flush_fc2", flush_cnt_a, PERF ? 32'd2 : 32'd0);
    chk("perf_flush_fc1", flush_cnt_b, PERF ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
